// File: rtl/fp_wire.sv
// Shared types and constants for the fp_unit result checker.
// Entry and port structs are sized for the widest (double) format.
package fp_wire;

  localparam int FLAGS_W  = 5;
  localparam int XLEN_MAX = 64;

  localparam logic [31:0] CANON_NAN32 = 32'h7FC0_0000;
  localparam logic [63:0] CANON_NAN64 = 64'h7FF8_0000_0000_0000;

  typedef struct packed {
    logic [XLEN_MAX-1:0] result;
    logic [FLAGS_W-1:0]  flags;
    logic                nan_relax;
  } fp_check_entry;

  typedef struct packed {
    logic                clear;
    logic                exp_valid;
    fp_check_entry       exp;
    logic                dut_valid;
    logic [XLEN_MAX-1:0] dut_result;
    logic [FLAGS_W-1:0]  dut_flags;
  } fp_check_in_type;

  typedef struct packed {
    logic                exp_ready;
    logic                mismatch;
    logic                err_sticky;
    logic                overflow;
    logic                underflow;
    logic                ff_valid;
    logic [XLEN_MAX-1:0] ff_ref_result;
    logic [XLEN_MAX-1:0] ff_calc_result;
    logic [FLAGS_W-1:0]  ff_ref_flags;
    logic [FLAGS_W-1:0]  ff_calc_flags;
  } fp_check_out_type;

  // Zero-extended canonical quiet NaN for a 32- or 64-bit result.
  function automatic logic [63:0] canon_nan(input int xlen);
    return (xlen == 64) ? CANON_NAN64 : {32'd0, CANON_NAN32};
  endfunction

endpackage

// File: rtl/fp_check_fifo.sv
// DEPTH-entry synchronous queue of expected entries; read data is the registered head, write visible next cycle.
// Push ignored when full, pop ignored when empty; clear empties it and wins over same-cycle push/pop.
module fp_check_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic [7:0],
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wdata,
  output entry_t           rdata,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  assign full      = (occ_q == OCC_W'(DEPTH));
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;
  assign do_push   = push & ~full & ~clear;
  assign do_pop    = pop & ~empty & ~clear;
  assign rdata     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      // Power-of-two depth, so pointers wrap by plain overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fp_check_queue.sv
// In-order fp result scoreboard: compare in the pop cycle, counters/mismatch/capture update one edge later.
// exp_ready drops at full (a same-cycle pop does not free space); no backpressure on the DUT side.
module fp_check_queue
  import fp_wire::*;
#(
  parameter int  XLEN  = 32,
  parameter int  MAN_W = 23,
  parameter int  DEPTH = 8,
  parameter int  CNT_W = 32,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               exp_valid,
  output logic               exp_ready,
  input  logic [XLEN-1:0]    exp_result,
  input  logic [FLAGS_W-1:0] exp_flags,
  input  logic               exp_nan_relax,
  input  logic               dut_valid,
  input  logic [XLEN-1:0]    dut_result,
  input  logic [FLAGS_W-1:0] dut_flags,
  output logic [OCC_W-1:0]   occupancy,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   fail_count,
  output logic               mismatch,
  output logic               err_sticky,
  output logic               overflow,
  output logic               underflow,
  output logic               ff_valid,
  output logic [XLEN-1:0]    ff_ref_result,
  output logic [XLEN-1:0]    ff_calc_result,
  output logic [FLAGS_W-1:0] ff_ref_flags,
  output logic [FLAGS_W-1:0] ff_calc_flags
);

  typedef struct packed {
    logic [XLEN-1:0]    result;
    logic [FLAGS_W-1:0] flags;
    logic               nan_relax;
  } chk_entry_t;

  localparam logic [63:0]      CANON_WIDE = canon_nan(XLEN);
  localparam logic [XLEN-1:0]  CANON_NAN  = CANON_WIDE[XLEN-1:0];

  chk_entry_t         wr_entry, head;
  logic               full, empty;
  logic               pop_ok, cmp_pass;
  logic [XLEN-1:0]    rdiff;
  logic [FLAGS_W-1:0] fdiff;

  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic               mismatch_q, mismatch_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               ff_valid_q, ff_valid_d;
  logic [XLEN-1:0]    ff_ref_res_q, ff_ref_res_d;
  logic [XLEN-1:0]    ff_calc_res_q, ff_calc_res_d;
  logic [FLAGS_W-1:0] ff_ref_flg_q, ff_ref_flg_d;
  logic [FLAGS_W-1:0] ff_calc_flg_q, ff_calc_flg_d;

  assign wr_entry = '{result: exp_result, flags: exp_flags, nan_relax: exp_nan_relax};

  fp_check_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (chk_entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .push      (exp_valid),
    .pop       (dut_valid),
    .wdata     (wr_entry),
    .rdata     (head),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  assign exp_ready = ~full;
  assign pop_ok    = dut_valid & ~empty;

  // Relaxed entries accept any NaN sign/payload when the DUT returns the canonical qNaN.
  always_comb begin
    rdiff = head.result ^ dut_result;
    fdiff = head.flags ^ dut_flags;
    if (head.nan_relax && (dut_result == CANON_NAN)) begin
      rdiff[XLEN-1]    = 1'b0;
      rdiff[MAN_W-2:0] = '0;
    end
    cmp_pass = (rdiff == '0) && (fdiff == '0);
  end

  always_comb begin
    pass_cnt_d    = pass_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    mismatch_d    = 1'b0;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    ff_valid_d    = ff_valid_q;
    ff_ref_res_d  = ff_ref_res_q;
    ff_calc_res_d = ff_calc_res_q;
    ff_ref_flg_d  = ff_ref_flg_q;
    ff_calc_flg_d = ff_calc_flg_q;
    err_d         = err_q;
    if (clear) begin
      pass_cnt_d    = '0;
      fail_cnt_d    = '0;
      ovf_d         = 1'b0;
      unf_d         = 1'b0;
      ff_valid_d    = 1'b0;
      ff_ref_res_d  = '0;
      ff_calc_res_d = '0;
      ff_ref_flg_d  = '0;
      ff_calc_flg_d = '0;
      err_d         = 1'b0;
    end else begin
      if (exp_valid && full) ovf_d = 1'b1;
      if (dut_valid && empty) unf_d = 1'b1;
      if (pop_ok) begin
        if (cmp_pass) begin
          if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end else begin
          if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          mismatch_d = 1'b1;
          if (!ff_valid_q) begin
            ff_valid_d    = 1'b1;
            ff_ref_res_d  = head.result;
            ff_calc_res_d = dut_result;
            ff_ref_flg_d  = head.flags;
            ff_calc_flg_d = dut_flags;
          end
        end
      end
      err_d = err_q | ovf_d | unf_d | mismatch_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      mismatch_q    <= 1'b0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      ff_valid_q    <= 1'b0;
      ff_ref_res_q  <= '0;
      ff_calc_res_q <= '0;
      ff_ref_flg_q  <= '0;
      ff_calc_flg_q <= '0;
    end else begin
      pass_cnt_q    <= pass_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      mismatch_q    <= mismatch_d;
      err_q         <= err_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
      ff_valid_q    <= ff_valid_d;
      ff_ref_res_q  <= ff_ref_res_d;
      ff_calc_res_q <= ff_calc_res_d;
      ff_ref_flg_q  <= ff_ref_flg_d;
      ff_calc_flg_q <= ff_calc_flg_d;
    end
  end

  assign pass_count     = pass_cnt_q;
  assign fail_count     = fail_cnt_q;
  assign mismatch       = mismatch_q;
  assign err_sticky     = err_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;
  assign ff_valid       = ff_valid_q;
  assign ff_ref_result  = ff_ref_res_q;
  assign ff_calc_result = ff_calc_res_q;
  assign ff_ref_flags   = ff_ref_flg_q;
  assign ff_calc_flags  = ff_calc_flg_q;

endmodule

// File: tb/tb_fp_check_queue.sv
// Bench for fp_check_queue: scoreboard model of the expected queue plus a verdict table and corner sequences.
module tb_fp_check_queue;

  localparam int XLEN  = 32;
  localparam int MAN_W = 23;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam int OCC_W = 4;

  logic             clock = 1'b0;
  logic             reset, clear;
  logic             exp_valid, exp_ready, exp_nan_relax;
  logic [XLEN-1:0]  exp_result;
  logic [4:0]       exp_flags;
  logic             dut_valid;
  logic [XLEN-1:0]  dut_result;
  logic [4:0]       dut_flags;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] pass_count, fail_count;
  logic             mismatch, err_sticky, overflow, underflow, ff_valid;
  logic [XLEN-1:0]  ff_ref_result, ff_calc_result;
  logic [4:0]       ff_ref_flags, ff_calc_flags;

  always #5 clock = ~clock;

  fp_check_queue #(.XLEN(XLEN), .MAN_W(MAN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_result(exp_result),
    .exp_flags(exp_flags), .exp_nan_relax(exp_nan_relax),
    .dut_valid(dut_valid), .dut_result(dut_result), .dut_flags(dut_flags),
    .occupancy(occupancy), .pass_count(pass_count), .fail_count(fail_count),
    .mismatch(mismatch), .err_sticky(err_sticky), .overflow(overflow), .underflow(underflow),
    .ff_valid(ff_valid), .ff_ref_result(ff_ref_result), .ff_calc_result(ff_calc_result),
    .ff_ref_flags(ff_ref_flags), .ff_calc_flags(ff_calc_flags)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboard state
  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
    bit          relax;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_pass, m_fail;
  bit          m_ovf, m_unf, m_err, m_mism, m_ffv;
  logic [31:0] m_ffr, m_ffc;
  logic [4:0]  m_fffr, m_fffc;

  task automatic model_clear();
    mq.delete();
    m_pass = 0; m_fail = 0;
    m_ovf = 0; m_unf = 0; m_err = 0; m_mism = 0; m_ffv = 0;
    m_ffr = '0; m_ffc = '0; m_fffr = '0; m_fffc = '0;
  endtask

  function automatic bit model_pass(input ent_t e, input logic [31:0] c, input logic [4:0] cf);
    logic [31:0] d;
    d = e.r ^ c;
    if (e.relax && c == 32'h7FC0_0000) d = d & 32'h7FC0_0000;
    return (d == 32'd0) && (e.f == cf);
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".occupancy"}, occupancy, mq.size());
    check({tag, ".exp_ready"}, exp_ready, mq.size() < DEPTH);
    check({tag, ".pass_count"}, pass_count, m_pass);
    check({tag, ".fail_count"}, fail_count, m_fail);
    check({tag, ".mismatch"}, mismatch, m_mism);
    check({tag, ".overflow"}, overflow, m_ovf);
    check({tag, ".underflow"}, underflow, m_unf);
    check({tag, ".err_sticky"}, err_sticky, m_err);
    check({tag, ".ff_valid"}, ff_valid, m_ffv);
    check({tag, ".ff_ref_result"}, ff_ref_result, m_ffr);
    check({tag, ".ff_calc_result"}, ff_calc_result, m_ffc);
    check({tag, ".ff_flags"}, {ff_ref_flags, ff_calc_flags}, {m_fffr, m_fffc});
  endtask

  task automatic idle_inputs();
    exp_valid = 0; exp_result = '0; exp_flags = '0; exp_nan_relax = 0;
    dut_valid = 0; dut_result = '0; dut_flags = '0; clear = 0;
  endtask

  // One clock: drive, update the scoreboard at the edge, check just after it.
  task automatic cycle(input bit push, input logic [31:0] pr, input logic [4:0] pf, input bit prelax,
                       input bit pop, input logic [31:0] cr, input logic [4:0] cf);
    int   sz;
    ent_t e;
    exp_valid = push; exp_result = pr; exp_flags = pf; exp_nan_relax = prelax;
    dut_valid = pop;  dut_result = cr; dut_flags = cf;
    @(posedge clock);
    sz = mq.size();
    m_mism = 0;
    if (pop) begin
      if (sz == 0) m_unf = 1;
      else begin
        e = mq.pop_front();
        if (model_pass(e, cr, cf)) m_pass++;
        else begin
          m_fail++;
          m_mism = 1;
          if (!m_ffv) begin
            m_ffv = 1; m_ffr = e.r; m_ffc = cr; m_fffr = e.f; m_fffc = cf;
          end
        end
      end
    end
    if (push) begin
      if (sz == DEPTH) m_ovf = 1;
      else mq.push_back('{r: pr, f: pf, relax: prelax});
    end
    m_err = m_err | m_ovf | m_unf | m_mism;
    #1;
    idle_inputs();
    check_state("cyc");
  endtask

  task automatic push_e(input logic [31:0] r, input logic [4:0] f, input bit relax);
    cycle(1, r, f, relax, 0, '0, '0);
  endtask

  task automatic pop_e(input logic [31:0] c, input logic [4:0] f);
    cycle(0, '0, '0, 0, 1, c, f);
  endtask

  task automatic do_clear(input bit with_traffic);
    clear = 1;
    exp_valid = with_traffic; exp_result = 32'h3F80_0000;
    dut_valid = with_traffic; dut_result = 32'h1234_5678;
    #1;
    check_state("clr_pre");
    @(posedge clock);
    model_clear();
    #1;
    idle_inputs();
    check_state("clr_post");
  endtask

  typedef struct {
    bit          clr;
    logic [31:0] r;
    logic [4:0]  rf;
    bit          relax;
    logic [31:0] c;
    logic [4:0]  cf;
    bit          pass;
  } vec_t;

  vec_t vt[8];

  task automatic apply_vec(input int i);
    logic [CNT_W-1:0] f0, p0;
    if (vt[i].clr) do_clear(0);
    push_e(vt[i].r, vt[i].rf, vt[i].relax);
    f0 = fail_count; p0 = pass_count;
    pop_e(vt[i].c, vt[i].cf);
    check($sformatf("vec%0d.mismatch", i), mismatch, !vt[i].pass);
    check($sformatf("vec%0d.fail_inc", i), fail_count - f0, vt[i].pass ? 0 : 1);
    check($sformatf("vec%0d.pass_inc", i), pass_count - p0, vt[i].pass ? 1 : 0);
  endtask

  initial begin
    vt[0] = '{0, 32'hFFC0_0001, 5'h10, 1, 32'h7FC0_0000, 5'h10, 1};
    vt[1] = '{0, 32'hFFC0_0001, 5'h10, 0, 32'h7FC0_0000, 5'h10, 0};
    vt[2] = '{1, 32'h0000_0000, 5'h01, 0, 32'h0000_0000, 5'h00, 0};
    vt[3] = '{0, 32'h4000_0000, 5'h00, 0, 32'h4040_0000, 5'h00, 0};
    vt[4] = '{0, 32'h7FC0_0001, 5'h00, 1, 32'h7FC0_0000, 5'h00, 1};
    vt[5] = '{0, 32'h7F80_0000, 5'h00, 1, 32'h7FC0_0000, 5'h00, 0};
    vt[6] = '{0, 32'hFFC0_0000, 5'h00, 1, 32'h7FC0_0001, 5'h00, 0};
    vt[7] = '{0, 32'h3F80_0000, 5'h00, 0, 32'h3F80_0000, 5'h00, 1};

    idle_inputs();
    model_clear();
    reset = 0;
    #2;
    check_state("reset");
    check("reset.exp_ready_one", exp_ready, 1);
    @(negedge clock);
    reset = 1;

    // Latency-1 stream
    for (int i = 0; i < 10; i++) begin
      push_e(32'h3F80_0000, 5'h00, 0);
      pop_e(32'h3F80_0000, 5'h00);
    end
    check("lat1.pass_count", pass_count, 10);
    check("lat1.fail_count", fail_count, 0);
    check("lat1.err_sticky", err_sticky, 0);

    // Pipelined: 8 outstanding, returned 5 cycles after the last issue
    for (int i = 0; i < 8; i++) push_e(32'h4000_0000 + i, 5'(i), 0);
    check("pipe.exp_ready_full", exp_ready, 0);
    check("pipe.occ_full", occupancy, 8);
    repeat (4) cycle(0, '0, '0, 0, 0, '0, '0);
    for (int i = 0; i < 8; i++) pop_e(32'h4000_0000 + i, 5'(i));
    check("pipe.occ_empty", occupancy, 0);
    check("pipe.pass_count", pass_count, 18);
    check("pipe.fail_count", fail_count, 0);

    // Verdict table, first the NaN pair after a clear
    do_clear(0);
    for (int i = 0; i < 2; i++) apply_vec(i);
    check("nan.fail_count", fail_count, 1);
    check("nan.ff_ref_result", ff_ref_result, 32'hFFC0_0001);
    check("nan.ff_calc_result", ff_calc_result, 32'h7FC0_0000);
    for (int i = 2; i < 8; i++) apply_vec(i);
    check("tbl.fail_count", fail_count, 4);
    check("tbl.pass_count", pass_count, 2);
    check("tbl.ff_ref_flags", ff_ref_flags, 5'h01);
    check("tbl.ff_calc_flags", ff_calc_flags, 5'h00);
    check("tbl.ff_ref_result", ff_ref_result, 32'h0000_0000);
    check("tbl.ff_calc_result", ff_calc_result, 32'h0000_0000);

    // Overflow, full push+pop, mid push+pop, underflow with same-cycle push
    do_clear(0);
    for (int i = 0; i < 8; i++) push_e(32'h100 + i, 5'h00, 0);
    push_e(32'hDEAD_0000, 5'h00, 0);
    check("ovf.overflow", overflow, 1);
    check("ovf.occ", occupancy, 8);
    cycle(1, 32'hDEAD_0001, 5'h00, 0, 1, 32'h100, 5'h00);
    check("fullpp.occ", occupancy, 7);
    for (int i = 1; i < 8; i++) pop_e(32'h100 + i, 5'h00);
    check("ovf.fail_count", fail_count, 0);
    push_e(32'hA, 5'h00, 0);
    cycle(1, 32'hB, 5'h00, 0, 1, 32'hA, 5'h00);
    check("midpp.occ", occupancy, 1);
    pop_e(32'hB, 5'h00);
    cycle(1, 32'hC, 5'h02, 0, 1, 32'hC, 5'h02);
    check("unf.underflow", underflow, 1);
    check("unf.occ", occupancy, 1);
    check("unf.pass_count", pass_count, 10);
    pop_e(32'hC, 5'h02);
    check("unf.drain_pass", pass_count, 11);

    // Asynchronous reset mid-run
    do_clear(0);
    for (int i = 0; i < 6; i++) push_e(32'h3F80_0000, 5'h00, 0);
    pop_e(32'h0, 5'h00);
    #2;
    reset = 0;
    #1;
    check("areset.occ", occupancy, 0);
    check("areset.exp_ready", exp_ready, 1);
    check("areset.counts", {pass_count, fail_count}, 64'd0);
    check("areset.bits", {mismatch, err_sticky, overflow, underflow, ff_valid}, 5'd0);
    check("areset.ff", {ff_ref_result, ff_calc_result, ff_ref_flags, ff_calc_flags}, 74'd0);
    model_clear();
    @(negedge clock);
    reset = 1;
    cycle(0, '0, '0, 0, 0, '0, '0);

    // Synchronous clear mid-run, with push/pop in the clear cycle
    for (int i = 0; i < 6; i++) push_e(32'h3F80_0000, 5'h00, 0);
    pop_e(32'h0, 5'h00);
    check("sclr.pre_occ", occupancy, 5);
    do_clear(1);
    check("sclr.occ", occupancy, 0);
    check("sclr.counts", {pass_count, fail_count}, 64'd0);
    check("sclr.err_sticky", err_sticky, 0);
    push_e(32'h1, 5'h00, 0);
    pop_e(32'h1, 5'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
